// File: rtl/simple_lane_unpacker_pkg.sv
// Shared types and constants for the lane unpacker.
package simple_lane_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int WORD_WIDTH_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unpack_state_e;

    function automatic int num_lanes(input int word_w, input int data_w);
        return word_w / data_w;
    endfunction

endpackage

// File: rtl/simple_lane_unpacker_lane_find_next.sv
// Priority encoder: finds the first non-zero lane at or above start, and
// reports whether another non-zero lane exists above the one found.
module lane_find_next #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = 2
) (
    input  logic [NUM_LANES*DATA_WIDTH-1:0] word,
    input  logic [LANE_W:0]                 start,
    output logic [LANE_W-1:0]               idx,
    output logic                            found,
    output logic                            more_after
);

    // Scan lanes low to high; the first hit wins, any later hit sets more_after.
    always_comb begin
        idx        = '0;
        found      = 1'b0;
        more_after = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if ((i >= int'(start)) && (word[i*DATA_WIDTH +: DATA_WIDTH] != '0)) begin
                if (found) begin
                    more_after = 1'b1;
                end else begin
                    idx   = LANE_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/simple_lane_unpacker.sv
// Unpacks one WORD_WIDTH word into DATA_WIDTH lanes, lane 0 first, over
// valid/ready on both sides. One word in flight; a new word may be accepted
// on the cycle the last lane retires so consecutive words have no bubble.
// Optional feature macro: SIMPLE_LANE_UNPACKER_ZERO_SKIP_EN (skip all-zero lanes).
//
// state | meaning
// IDLE  | no word held, ready for input
// SEND  | word_q held, lane_q selects the lane on the output
module simple_lane_unpacker
    import simple_lane_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int WORD_WIDTH = WORD_WIDTH_DEF,
    localparam int NUM_LANES  = num_lanes(WORD_WIDTH, DATA_WIDTH),
    localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LANE_W-1:0]     out_lane,
    output logic                  out_last
);

    unpack_state_e         state_q, state_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [LANE_W-1:0]     lane_q, lane_d;

    logic                  out_hs;
    logic                  in_hs;
    logic                  last;
    logic [LANE_W-1:0]     load_idx;
    logic                  load_nonempty;
    logic [LANE_W-1:0]     adv_idx;

`ifdef SIMPLE_LANE_UNPACKER_ZERO_SKIP_EN
    logic adv_found;
    logic adv_more;
    logic load_more;
    logic unused_find;

    // First non-zero lane of the incoming word; none found means an empty word.
    lane_find_next #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (NUM_LANES),
        .LANE_W     (LANE_W)
    ) u_find_load (
        .word       (in_word),
        .start      ('0),
        .idx        (load_idx),
        .found      (load_nonempty),
        .more_after (load_more)
    );

    // Next non-zero lane above the current one; none found means this lane is last.
    lane_find_next #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (NUM_LANES),
        .LANE_W     (LANE_W)
    ) u_find_adv (
        .word       (word_q),
        .start      ({1'b0, lane_q} + (LANE_W+1)'(1)),
        .idx        (adv_idx),
        .found      (adv_found),
        .more_after (adv_more)
    );

    assign last        = !adv_found;
    assign unused_find = ^{load_more, adv_more};
`else
    assign load_idx      = '0;
    assign load_nonempty = 1'b1;
    assign adv_idx       = lane_q + LANE_W'(1);
    assign last          = (lane_q == LANE_W'(NUM_LANES - 1));
`endif

    assign out_valid = (state_q == SEND);
    assign out_lane  = lane_q;
    assign out_last  = out_valid && last;
    assign out_hs    = out_valid && out_ready;
    assign in_ready  = (state_q == IDLE) || (out_hs && last);
    assign in_hs     = in_valid && in_ready;

    // Lane select mux, driven purely from registers.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                out_data = word_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: load on input handshake, advance on output handshake.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    word_d  = in_word;
                    lane_d  = load_idx;
                    state_d = load_nonempty ? SEND : IDLE;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (!last) begin
                        lane_d = adv_idx;
                    end else if (in_hs) begin
                        word_d  = in_word;
                        lane_d  = load_idx;
                        state_d = load_nonempty ? SEND : IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
        end
    end

endmodule

// File: tb/tb_simple_lane_unpacker.sv
// Directed bench for simple_lane_unpacker (default 8-bit lanes, 32-bit word).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_simple_lane_unpacker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    simple_lane_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    // observed vector: {out_valid, out_data, out_lane, out_last, in_ready}
    function automatic logic [12:0] obs();
        return {out_valid, out_data, out_lane, out_last, in_ready};
    endfunction

    task automatic test_reset();
        logic [12:0] exp;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
        repeat (2) @(negedge clk);
        #1;
        exp = {1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
        total++;
        if (obs() !== exp) begin
            bad++; $display("FAIL reset: got %h want %h", obs(), exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0]  d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [12:0] exp;
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'hDDCC_BBAA; out_ready = 1'b1;
        #1;
        exp = {1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
        total++;
        if (obs() !== exp) begin
            bad++; $display("FAIL single accept: got %h want %h", obs(), exp);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            exp = {1'b1, d[k], 2'(k), (k == 3), (k == 3)};
            total++;
            if (obs() !== exp) begin
                bad++; $display("FAIL single beat %0d: got %h want %h", k, obs(), exp);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL single drain: got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        logic [12:0] exp;
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'h1122_3344; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_valid = (k <= 4);
            in_word  = 32'h5566_7788;
            #1;
            exp = {1'b1, d[k-1], 2'((k - 1) % 4), (k == 4 || k == 8), (k == 4 || k == 8)};
            total++;
            if (obs() !== exp) begin
                bad++; $display("FAIL b2b beat %0d: got %h want %h", k, obs(), exp);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [7:0]  d [7] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04};
        logic [1:0]  l [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        logic [12:0] exp;
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'h0403_0201; out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            out_ready = !(k >= 2 && k <= 4);
            in_valid  = (k == 3 || k == 4);
            in_word   = 32'hFFFF_FFFF;
            #1;
            exp = {1'b1, d[k-1], l[k-1], (k == 7), (k == 7)};
            total++;
            if (obs() !== exp) begin
                bad++; $display("FAIL stall beat %0d: got %h want %h", k, obs(), exp);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL stall drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp;
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'hCAFE_BABE; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        exp = {1'b1, 8'hFE, 2'd2, 1'b0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++; $display("FAIL rst_mid lane2: got %h want %h", obs(), exp);
        end
        rst_n = 1'b0;
        #1;
        exp = {1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
        total++;
        if (obs() !== exp) begin
            bad++; $display("FAIL rst_mid assert: got %h want %h", obs(), exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (obs() !== exp) begin
                bad++; $display("FAIL rst_mid after %0d: got %h want %h", k, obs(), exp);
            end
        end
    endtask

`ifdef SIMPLE_LANE_UNPACKER_ZERO_SKIP_EN
    task automatic test_zero_skip();
        logic [12:0] exp;
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'h0012_0034; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        exp = {1'b1, 8'h34, 2'd0, 1'b0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++; $display("FAIL skip beat0: got %h want %h", obs(), exp);
        end
        @(negedge clk);
        #1;
        exp = {1'b1, 8'h12, 2'd2, 1'b1, 1'b1};
        total++;
        if (obs() !== exp) begin
            bad++; $display("FAIL skip beat1: got %h want %h", obs(), exp);
        end
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'h0000_0000;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL skip zero accept: got %b want 01", {out_valid, in_ready});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            total++;
            if ({out_valid, in_ready} !== 2'b01) begin
                bad++; $display("FAIL skip zero idle %0d: got %b want 01", k, {out_valid, in_ready});
            end
        end
    endtask
`else
    task automatic test_zero_word();
        logic [12:0] exp;
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'h0000_0000; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            exp = {1'b1, 8'h00, 2'(k), (k == 3), (k == 3)};
            total++;
            if (obs() !== exp) begin
                bad++; $display("FAIL zero beat %0d: got %h want %h", k, obs(), exp);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL zero drain: got %b want 0", out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef SIMPLE_LANE_UNPACKER_ZERO_SKIP_EN
        test_zero_skip();
`else
        test_zero_word();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
